// File: rtl/dlfloat_pkg.sv
// Shared DLFloat definitions: default field widths, field layout, special words,
// accumulator FSM states and exponent classification helpers.
package dlfloat_pkg;

  localparam int EXP_W_DEF = 6;
  localparam int MAN_W_DEF = 9;
  localparam int BIAS_DEF  = (1 << (EXP_W_DEF - 1)) - 1;
  localparam int W_DEF     = 1 + EXP_W_DEF + MAN_W_DEF;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } dlf_t;

  localparam logic [W_DEF-1:0] NAN_WORD  = '1;
  localparam logic [W_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  // Exponent fields arrive zero-extended so one helper serves every EXP_W.
  function automatic logic is_nan(input logic [31:0] e, input int ew);
    return e == ((32'd1 << ew) - 32'd1);
  endfunction

  function automatic logic is_zero(input logic [31:0] e);
    return e == 32'd0;
  endfunction

endpackage

// File: rtl/dlfloat_add_norm.sv
// Combinational DLFloat adder: align smaller operand, add/subtract magnitudes,
// renormalise on the leading one, truncate, then saturate to NaN or flush to +0.
module dlfloat_add_norm
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf,
  output logic         unf
);

  localparam int MW = MAN_W + 1;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] E_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] E_ZERO = '0;

  logic                    sa, sb, a_big, big_s;
  logic [EXP_W-1:0]        ea, eb, big_e, sml_e, shift;
  logic [MAN_W-1:0]        fa, fb;
  logic [MW-1:0]           big_m, sml_m, sml_al;
  logic [MW:0]             raw, norm;
  logic signed [XW-1:0]    e_x;
  int                      lead;
  logic                    unused_norm;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign a_big = a[W-2:0] >= b[W-2:0];
  assign unused_norm = norm[MW] ^ norm[0];

  // NOTE: every always_comb output is given a default first, so no path can leave a latch behind.
  always_comb begin
    sum    = '0;
    ovf    = 1'b0;
    unf    = 1'b0;
    big_s  = a_big ? sa : sb;
    big_e  = a_big ? ea : eb;
    sml_e  = a_big ? eb : ea;
    big_m  = {1'b1, a_big ? fa : fb};
    sml_m  = {1'b1, a_big ? fb : fa};
    shift  = big_e - sml_e;
    sml_al = sml_m >> shift;
    raw    = (sa == sb) ? ({1'b0, big_m} + {1'b0, sml_al})
                        : ({1'b0, big_m} - {1'b0, sml_al});
    lead   = 0;
    for (int i = 0; i <= MW; i++) begin
      if (raw[i]) lead = i;
    end
    // Leading one lands on bit MW; exponent moves by the same amount.
    norm = raw << (MW - lead);
    e_x  = XW'(big_e) + XW'(lead) - XW'(MAN_W);

    if (is_nan(32'(ea), EXP_W) || is_nan(32'(eb), EXP_W)) begin
      sum = '1;
    end else if (is_zero(32'(ea)) && is_zero(32'(eb))) begin
      sum = '0;
    end else if (is_zero(32'(ea))) begin
      sum = b;
    end else if (is_zero(32'(eb))) begin
      sum = a;
    end else if (raw == '0) begin
      sum = '0;
    end else if (e_x >= E_MAX) begin
      sum = '1;
      ovf = 1'b1;
    end else if (e_x <= E_ZERO) begin
      sum = '0;
      unf = 1'b1;
    end else begin
      sum = {big_s, e_x[EXP_W-1:0], norm[MAN_W:1]};
    end
  end

endmodule

// File: rtl/dlfloat_mac_stream.sv
// Streaming DLFloat MAC: framed (a,b) pairs in, sum and pair count out.
// Define DLF_MAC_STATUS_EN for sticky per-frame {nan, ovf, unf} on out_flags.
module dlfloat_mac_stream
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int CNT_W = 8,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic [2:0]       out_flags
);

  localparam int MW   = MAN_W + 1;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [XW-1:0] E_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] E_ZERO = '0;

  state_t               state_q, state_d;
  logic                 accept, res_taken, load_out, prod_vld_q;
  logic [CNT_W-1:0]     cnt_q, cnt_inc;
  logic [W-1:0]         acc_q, prod_q, add_sum, mul_word;
  logic                 add_ovf, add_unf, mul_ovf, mul_unf, mul_nan_in;
  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb, mman;
  logic [2*MW-1:0]      mprod;
  logic signed [XW-1:0] mexp;
  logic                 unused_bits;

  // clr blocks acceptance in the same cycle so a pair is never half-taken.
  assign in_ready  = !rst && !clr && (state_q == IDLE || state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign res_taken = (state_q == DONE) && out_ready;
  assign load_out  = (state_q == DRAIN) && !prod_vld_q;
  assign cnt_inc   = cnt_q + 1'b1;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign mprod = (2*MW)'({1'b1, fa}) * (2*MW)'({1'b1, fb});
  assign mexp  = XW'(ea) + XW'(eb) - XW'(BIAS) + XW'(mprod[2*MW-1]);
  assign mman  = mprod[2*MW-1] ? mprod[2*MW-2 -: MAN_W] : mprod[2*MW-3 -: MAN_W];
  assign unused_bits = ^mprod[MW-2:0];

  always_comb begin
    mul_word   = '0;
    mul_ovf    = 1'b0;
    mul_unf    = 1'b0;
    mul_nan_in = is_nan(32'(ea), EXP_W) || is_nan(32'(eb), EXP_W);
    if (mul_nan_in) begin
      mul_word = '1;
    end else if (is_zero(32'(ea)) || is_zero(32'(eb))) begin
      mul_word = '0;
    end else if (mexp >= E_MAX) begin
      mul_word = '1;
      mul_ovf  = 1'b1;
    end else if (mexp <= E_ZERO) begin
      mul_unf  = 1'b1;
    end else begin
      mul_word = {sa ^ sb, mexp[EXP_W-1:0], mman};
    end
  end

  dlfloat_add_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_add (
    .a   (acc_q),
    .b   (prod_q),
    .sum (add_sum),
    .ovf (add_ovf),
    .unf (add_unf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q    <= IDLE;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data   <= '0;
      out_count  <= '0;
    end else begin
      state_q    <= state_d;
      prod_vld_q <= accept;
      if (accept) prod_q <= mul_word;
      if (res_taken)       acc_q <= '0;
      else if (prod_vld_q) acc_q <= add_sum;
      if (res_taken)   cnt_q <= '0;
      else if (accept) cnt_q <= cnt_inc;
      if (load_out) begin
        out_data  <= acc_q;
        out_count <= cnt_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = (in_last || &cnt_inc) ? DRAIN : ACCUM;
      DRAIN:       if (!prod_vld_q) state_d = DONE;
      DONE:        if (out_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

`ifdef DLF_MAC_STATUS_EN
  logic [2:0] frm_flags_q;

  always_ff @(posedge clk) begin
    if (rst || clr || res_taken) begin
      frm_flags_q <= '0;
      out_flags   <= '0;
    end else begin
      frm_flags_q <= frm_flags_q
                   | (accept     ? {mul_nan_in, mul_ovf, mul_unf} : 3'b000)
                   | (prod_vld_q ? {1'b0, add_ovf, add_unf}       : 3'b000);
      if (load_out) out_flags <= frm_flags_q;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{mul_nan_in, mul_ovf, mul_unf, add_ovf, add_unf};
  assign out_flags    = 3'b000;
`endif

endmodule
